// File: rtl/reflet_float_mult_arbiter.sv
// reflet_float_mult_arbiter
//   Shares one reflet_float_mult_mult multiplier between several requesters.
//   Pending requests are arbitrated. The winner's operands are latched and driven
//   to the multiplier with its enable set. When the multiplier reports ready, the
//   product is registered and done pulses for one cycle to the winner.
//
// Parameters
//   size        operand width; the product is 2*size bits
//   requesters  number of requester ports N (N >= 2)
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   req          per-requester request, held until its done pulse
//   in1_bus      operand 1 of requester i at [i*size +: size]
//   in2_bus      operand 2 of requester i at [i*size +: size]
//   grant        one-hot owner of the multiplier
//   done         one-cycle pulse: result is valid for requester i
//   result       registered product, held until the next capture
//   busy         high whenever the arbiter is not idle
//   mult_enable  multiplier enable
//   mult_in1     multiplier operand 1
//   mult_in2     multiplier operand 2
//   mult_result  multiplier product
//   mult_ready   multiplier ready
//
// Configuration
//   REFLET_FLOAT_MULT_ARB_PRIORITY_EN: when defined, arbitration uses fixed
//   priority (the lowest index wins) and the rotation pointer stays at 0.
//   When it is not defined, arbitration is round-robin.

module reflet_float_mult_arbiter #(
  parameter int unsigned size       = 10,
  parameter int unsigned requesters = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [requesters-1:0]        req,
  input  logic [requesters*size-1:0]   in1_bus,
  input  logic [requesters*size-1:0]   in2_bus,
  output logic [requesters-1:0]        grant,
  output logic [requesters-1:0]        done,
  output logic [2*size-1:0]            result,
  output logic                         busy,
  output logic                         mult_enable,
  output logic [size-1:0]              mult_in1,
  output logic [size-1:0]              mult_in2,
  input  logic [2*size-1:0]            mult_result,
  input  logic                         mult_ready
);

  localparam int unsigned IW = (requesters > 1) ? $clog2(requesters) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state, state_n;
  logic [IW-1:0]           ptr, ptr_n;
  logic [IW-1:0]           win, win_n;
  logic [requesters-1:0]   grant_n, done_n;
  logic [2*size-1:0]       result_n;
  logic                    enable_n;
  logic [size-1:0]         in1_n, in2_n;

  // Arbitration result
  logic                    found;
  logic [IW-1:0]           pick;
  logic [size-1:0]         sel1, sel2;

  // Search every requester once, starting at the rotation pointer (or at 0
  // in fixed-priority mode). The first asserted request wins. Its operands
  // are selected in the same pass.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    sel1  = '0;
    sel2  = '0;
    for (int unsigned i = 0; i < requesters; i++) begin
`ifdef REFLET_FLOAT_MULT_ARB_PRIORITY_EN
      idx = i;
`else
      idx = 32'(ptr) + i;
      if (idx >= requesters)
        idx = idx - requesters;
`endif
      if (!found && req[IW'(idx)]) begin
        found = 1'b1;
        pick  = IW'(idx);
        sel1  = in1_bus[idx*size +: size];
        sel2  = in2_bus[idx*size +: size];
      end
    end
  end

  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    win_n    = win;
    grant_n  = grant;
    done_n   = '0;
    result_n = result;
    enable_n = mult_enable;
    in1_n    = mult_in1;
    in2_n    = mult_in2;

    case (state)
      IDLE: begin
        enable_n = 1'b0;
        grant_n  = '0;
        if (found) begin
          win_n        = pick;
          grant_n[pick] = 1'b1;
          in1_n        = sel1;
          in2_n        = sel2;
          enable_n     = 1'b1;
          state_n      = RUN;
        end
      end

      RUN: begin
        // A withdrawn request abandons the operation. This check takes
        // precedence over a simultaneous ready, so a departed requester
        // never receives a done pulse.
        if (!req[win]) begin
          enable_n = 1'b0;
          grant_n  = '0;
          state_n  = IDLE;
        end else if (mult_ready) begin
          result_n    = mult_result;
          enable_n    = 1'b0;
          done_n[win] = 1'b1;
          state_n     = DONE;
        end
      end

      DONE: begin
        enable_n = 1'b0;
        grant_n  = '0;
        state_n  = IDLE;
`ifdef REFLET_FLOAT_MULT_ARB_PRIORITY_EN
        ptr_n = '0;
`else
        if (32'(win) == requesters - 1)
          ptr_n = '0;
        else
          ptr_n = win + 1'b1;
`endif
      end

      default: begin
        enable_n = 1'b0;
        grant_n  = '0;
        state_n  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      win         <= '0;
      grant       <= '0;
      done        <= '0;
      result      <= '0;
      mult_enable <= 1'b0;
      mult_in1    <= '0;
      mult_in2    <= '0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      win         <= win_n;
      grant       <= grant_n;
      done        <= done_n;
      result      <= result_n;
      mult_enable <= enable_n;
      mult_in1    <= in1_n;
      mult_in2    <= in2_n;
    end
  end

  assign busy = (state != IDLE);

endmodule
